seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//   Serial pattern transmitter; the source-side counterpart of the Mealy sequence detectors.
//   - Serializes a latched PAT_W-bit pattern, MSB first, onto a 1-bit stream (a / a_valid / a_ready).
//   - Repeats the pattern a programmable number of times, with optional idle gaps between repeats.
//   - Drives detector benches and loopback self-test.
// PARAMETERS
//   PAT_W    4   pattern width in bits (>=2)
//   CNT_W    8   width of repeat count
//   GAP_W    4   width of inter-pattern gap count
//   OVL_LEN  2   bits shared between back-to-back repeats in overlap mode (1..PAT_W-1)
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   start      in   1      request; accepted only in IDLE
//   pattern    in   PAT_W  pattern, sampled on start accept
//   repeat     in   CNT_W  number of pattern occurrences, sampled on start accept
//   gap        in   GAP_W  idle cycles between repeats, sampled on start accept
//   a_ready    in   1      sink accepts current bit
//   a          out  1      serial data; 0 whenever a_valid=0
//   a_valid    out  1      a carries a bit
//   busy       out  1      high in any state but IDLE
//   done       out  1      1-cycle pulse at transfer end
// BEHAVIOUR
//   - Reset (async, reset=0): state=IDLE; a=0, a_valid=0, busy=0, done=0; any transfer is abandoned.
//   - Outputs decode from registers only; no combinational path from inputs to outputs.
//   - FSM states: IDLE, SHIFT, GAP, FIN.
//   - IDLE: start=1 latches pattern/repeat/gap into pat_q/rep_q/gap_q.
//     - rep_q==0 -> FIN.
//     - else -> SHIFT with idx=PAT_W-1.
//   - Latency: start accepted at edge N -> first bit valid in cycle N+1.
//   - SHIFT: a=pat_q[idx], a_valid=1.
//     - A bit transfers when a_valid & a_ready at a clock edge.
//     - a_ready=0: a and idx hold, stall unbounded.
//     - Transfer with idx!=0: idx-1.
//     - Transfer with idx==0 (pattern complete): rep_q-1.
//       - rep_q was 1 -> FIN.
//       - else gap_q!=0 -> GAP, gap counter=gap_q.
//       - else -> SHIFT with idx=RESTART (below).
//   - GAP: a=0, a_valid=0; counter decrements each cycle; counter==1 -> SHIFT, idx=PAT_W-1.
//   - FIN: done=1 for exactly one cycle, busy=1 -> IDLE.
//   - start while busy (SHIFT/GAP/FIN) is ignored; latched values are not disturbed.
//   - Counters never wrap: rep_q and the gap counter stop at their terminal values.
//   - RESTART=PAT_W-1 unless overlap applies (see CONFIGURATION).
// CONFIGURATION
//   Macro SEQ_PATTERN_TX_OVERLAP_EN.
//   - Defined: back-to-back repeats (gap_q==0) use RESTART=PAT_W-1-OVL_LEN, but only when
//     pat_q[PAT_W-1 -: OVL_LEN]==pat_q[OVL_LEN-1:0]. The shared prefix is then not resent,
//     which matches an overlapping detector.
//     - Prefix!=suffix or gap_q!=0: full pattern each repeat.
//     - The first repeat is always full.
//   - Undefined: RESTART=PAT_W-1 always; every repeat is sent in full.
// TESTING
//   1. 1010, repeat=1, gap=0, a_ready=1 -> a=1,0,1,0 in cycles N+1..N+4; done in N+5; loopback detector 1 hit.
//   2. 1010, repeat=3, gap=0:
//      - OVERLAP_EN -> 10101010 (8 valid cycles), detector 3 hits.
//      - Undefined -> 101010101010 (12 cycles), detector 5 hits.
//   3. 1100, repeat=2, OVERLAP_EN -> prefix!=suffix, 11001100 (8 bits).
//      1010, repeat=2, gap=2 -> 1010, 2 cycles a_valid=0, then 1010 (no overlap).
//   4. 1010, repeat=2, a_ready toggling 1,0,0,1,... -> a stable while stalled; same 8-bit sequence; done once.
//   5. repeat=0 -> a_valid never high; done=1 in cycle N+1; busy=0 in N+2.
//   6. Second start mid-SHIFT -> ignored, stream unchanged.
//      reset=0 mid-SHIFT -> a/a_valid/busy=0 immediately.
//      After release, new start 0110 -> 0,1,1,0 normally.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : seq_pattern_tx_if                                     |
// | Brief    : 1-bit serial stream (a / a_valid / a_ready) interface  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface seq_pattern_tx_if;
    logic a;
    logic a_valid;
    logic a_ready;

    modport master (output a, output a_valid, input a_ready);
    modport slave  (input a, input a_valid, output a_ready);
endinterface : seq_pattern_tx_if
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : seq_pattern_tx                                        |
// | Brief    : Serial pattern transmitter, MSB first, N repeats with |
// |            optional gaps. Macro SEQ_PATTERN_TX_OVERLAP_EN skips  |
// |            the shared prefix on back-to-back repeats.            |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module seq_pattern_tx #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4,
    parameter int OVL_LEN = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PAT_W-1:0]   pattern,
    input  logic [CNT_W-1:0]   repeat_count,
    input  logic [GAP_W-1:0]   gap,
    seq_pattern_tx_if.master   tx,
    output logic               busy,
    output logic               done
);

    localparam int                 c_idx_w   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [c_idx_w-1:0] c_idx_top = c_idx_w'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat_q;
    logic [CNT_W-1:0]   r_rep_q;
    logic [GAP_W-1:0]   r_gap_q;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [c_idx_w-1:0] r_idx;
    logic               r_a;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic [c_idx_w-1:0] w_restart;
    logic [c_idx_w-1:0] w_idx_dec;

    assign w_idx_dec = r_idx - c_idx_w'(1);

`ifdef SEQ_PATTERN_TX_OVERLAP_EN
    localparam logic [c_idx_w-1:0] c_idx_ovl = c_idx_w'(PAT_W - 1 - OVL_LEN);
    // Only consulted on gapless repeats; prefix==suffix lets the detector reuse the tail.
    assign w_restart = (r_pat_q[PAT_W-1 -: OVL_LEN] == r_pat_q[OVL_LEN-1:0]) ? c_idx_ovl : c_idx_top;
`else
    assign w_restart = c_idx_top;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pat_q   <= '0;
            r_rep_q   <= '0;
            r_gap_q   <= '0;
            r_gap_cnt <= '0;
            r_idx     <= '0;
            r_a       <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pat_q <= pattern;
                        r_rep_q <= repeat_count;
                        r_gap_q <= gap;
                        r_busy  <= 1'b1;
                        if (repeat_count == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_idx   <= c_idx_top;
                            r_a     <= pattern[PAT_W-1];
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (tx.a_ready) begin
                        if (r_idx != '0) begin
                            r_idx <= w_idx_dec;
                            r_a   <= r_pat_q[w_idx_dec];
                        end else begin
                            r_rep_q <= r_rep_q - CNT_W'(1);
                            if (r_rep_q == CNT_W'(1)) begin
                                r_state <= S_FIN;
                                r_done  <= 1'b1;
                                r_a     <= 1'b0;
                                r_valid <= 1'b0;
                            end else if (r_gap_q != '0) begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= r_gap_q;
                                r_a       <= 1'b0;
                                r_valid   <= 1'b0;
                            end else begin
                                r_idx <= w_restart;
                                r_a   <= r_pat_q[w_restart];
                            end
                        end
                    end
                end
                S_GAP: begin
                    // Counter holds at 1 on exit rather than wrapping.
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_state <= S_SHIFT;
                        r_idx   <= c_idx_top;
                        r_a     <= r_pat_q[PAT_W-1];
                        r_valid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx.a       = r_a;
    assign tx.a_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule : seq_pattern_tx
`default_nettype wire
